// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter that owns one N_REQ-to-1 data mux and locks the grant for a whole burst.
// Optional stall watchdog: define MUX_SHARE_ARBITER_TIMEOUT_EN.
module mux_share_arbiter #(
    parameter int N_REQ          = 4,
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("mux_share_arbiter: N_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mux_share_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [N_REQ-1:0] sel_grant;
    logic             sel_found;
    logic             lock;
    logic             g_valid;
    logic             release_burst;
    logic             wd_fire;

    assign lock    = (state == ST_LOCK);
    assign busy    = lock;
    assign g_valid = |(req_valid & grant);

    // Search ptr, ptr+1, ... (wrapping) and keep the first requester found.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!sel_found && req_valid[IDX_W'(idx)]) begin
                sel_found              = 1'b1;
                sel_grant[IDX_W'(idx)] = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) g_idx = IDX_W'(i);
        end
    end

    assign next_ptr = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);

    // Shared channel: grant is one-hot or zero, so an AND-OR mux is sufficient.
    always_comb begin
        out_data  = '0;
        out_valid = lock & g_valid;
        out_last  = lock & |(req_last & grant);
        req_ready = grant & {N_REQ{lock & out_ready}};
        if (lock) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) out_data = req_data[i*W +: W];
            end
        end
    end

    assign release_burst = out_valid & out_ready & out_last;

`ifdef MUX_SHARE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;

    assign wd_fire = lock && !g_valid && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside LOCK, so every new grant starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_fire;
            if (!lock || g_valid || wd_fire) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state <= ST_LOCK;
                        grant <= sel_grant;
                    end
                end
                ST_LOCK: begin
                    if (release_burst || wd_fire) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        ptr   <= next_ptr;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed table-driven bench for mux_share_arbiter (N_REQ=4, W=8, TIMEOUT_CYCLES=16).
module tb_mux_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    mux_share_arbiter #(.N_REQ(4), .W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        ordy;
        logic [3:0]  e_grant;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [3:0]  e_rr;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic r, input logic [3:0] eg, input logic eov,
                                input logic [7:0] eod, input logic eol, input logic [3:0] err,
                                input logic eb);
        vec_t t;
        t.valid = v;  t.data = d;  t.last = l;  t.ordy = r;
        t.e_grant = eg; t.e_ov = eov; t.e_od = eod; t.e_ol = eol; t.e_rr = err; t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " grant"}, 32'(grant), 32'h0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    localparam logic [31:0] D_RR = 32'h13121110;
    localparam logic [3:0]  Z4   = 4'b0000;

    initial begin
        // Round-robin: idle/lock alternating, grants 0001,0010,0100,1000,0001
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, 4'b0001, 1, 8'h10, 1, 4'b0001, 1));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, 4'b0010, 1, 8'h11, 1, 4'b0010, 1));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, 4'b0100, 1, 8'h12, 1, 4'b0100, 1));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, 4'b1000, 1, 8'h13, 1, 4'b1000, 1));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1111, D_RR, 4'b1111, 1, 4'b0001, 1, 8'h10, 1, 4'b0001, 1));
        // Burst lock on requester 2 while requester 0 waits; 5-cycle backpressure on the last beat
        vecs.push_back(mk(4'b0101, 32'h00A10055, 4'b0001, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b0101, 32'h00A10055, 4'b0001, 1, 4'b0100, 1, 8'hA1, 0, 4'b0100, 1));
        vecs.push_back(mk(4'b0101, 32'h00A20055, 4'b0001, 1, 4'b0100, 1, 8'hA2, 0, 4'b0100, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0101, 32'h00A30055, 4'b0101, 0, 4'b0100, 1, 8'hA3, 1, Z4, 1));
        vecs.push_back(mk(4'b0101, 32'h00A30055, 4'b0101, 1, 4'b0100, 1, 8'hA3, 1, 4'b0100, 1));
        // Requester 3 idle, so requester 0 is next
        vecs.push_back(mk(4'b0001, 32'h00000055, 4'b0001, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b0001, 32'h00000055, 4'b0001, 1, 4'b0001, 1, 8'h55, 1, 4'b0001, 1));
        // From ptr=1 with 0 and 3 valid, requester 3 wins
        vecs.push_back(mk(4'b1001, 32'h77000055, 4'b1001, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b1001, 32'h77000055, 4'b1001, 1, 4'b1000, 1, 8'h77, 1, 4'b1000, 1));
        // Mid-burst valid drop holds the grant; other lines are ignored
        vecs.push_back(mk(4'b0001, 32'h00000055, 4'b0000, 1, Z4, 0, 8'h00, 0, Z4, 0));
        vecs.push_back(mk(4'b0001, 32'h00000055, 4'b0000, 1, 4'b0001, 1, 8'h55, 0, 4'b0001, 1));
        vecs.push_back(mk(4'b1110, 32'h00000055, 4'b0000, 1, 4'b0001, 0, 8'h55, 0, 4'b0001, 1));
        vecs.push_back(mk(4'b0001, 32'h00000055, 4'b0001, 1, 4'b0001, 1, 8'h55, 1, 4'b0001, 1));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1, Z4, 0, 8'h00, 0, Z4, 0));

        // Reset with all requesters valid
        rst_n = 1'b0; req_valid = 4'b1111; req_data = D_RR; req_last = 4'b1111; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_idle("reset");
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset timeout_err", 32'(timeout_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].valid; req_data = vecs[i].data;
            req_last  = vecs[i].last;  out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(vecs[i].e_ol));
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            @(posedge clk); #1;
        end

        // Async reset in the middle of beat 2 of a requester-1 burst
        req_valid = 4'b0010; req_data = 32'h0000B100; req_last = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        chk_idle("ar idle");
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar beat1 grant", 32'(grant), 32'h2);
        chk("ar beat1 data", 32'(out_data), 32'hB1);
        @(posedge clk); #1;
        req_data = 32'h0000B200;
        #1;
        chk("ar beat2 data", 32'(out_data), 32'hB2);
        chk("ar beat2 valid", 32'(out_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("ar asserted");
        chk("ar out_data", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 4'b0000;

        // Watchdog: requester 1 granted, then stalls for 16 cycles while requester 2 waits
        req_valid = 4'b0010; req_data = 32'h0; req_last = 4'b0000;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("wd stall%0d grant", c), 32'(grant), 32'h2);
            chk($sformatf("wd stall%0d timeout_err", c), 32'(timeout_err), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
`ifdef MUX_SHARE_ARBITER_TIMEOUT_EN
        chk("wd fire grant", 32'(grant), 32'h0);
        chk("wd fire timeout_err", 32'(timeout_err), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd regrant", 32'(grant), 32'h4);
        chk("wd pulse width", 32'(timeout_err), 32'h0);
`else
        chk("wd off grant", 32'(grant), 32'h2);
        chk("wd off timeout_err", 32'(timeout_err), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd off grant held", 32'(grant), 32'h2);
        chk("wd off busy", 32'(busy), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
